// File: rtl/mdio_master.sv
// mdio_master: clause-22 MDIO master; cmd_en/cmd_write/phy_addr/reg_addr/wr_data in, busy/done/rd_data out, mdc/mdio_out/mdio_oe/mdio_in pad side
module mdio_master #(
  parameter int MDC_HALF_PERIOD = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_en,
  input  logic        cmd_write,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in
);
  localparam int HW = $clog2(MDC_HALF_PERIOD);
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, TURNAROUND, DATA} state_t;
  state_t state, state_nxt;
  logic [HW-1:0] hcnt;
  logic [5:0] bcnt;
  logic phase, wr_q, done_q;
  logic [63:0] frame;
  logic [15:0] shreg;
  logic [1:0] sync;
  logic half_end, bit_end, last;
  assign half_end = hcnt == HW'(MDC_HALF_PERIOD - 1);
  assign bit_end = phase && half_end;
  assign last = state == DATA && bit_end && bcnt == 6'd63;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hcnt <= '0;
      bcnt <= '0;
      phase <= 1'b0;
      wr_q <= 1'b0;
      done_q <= 1'b0;
      frame <= '0;
      shreg <= '0;
      sync <= '0;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      sync <= {sync[0], mdio_in};
      done_q <= last;
      if (state == IDLE) begin
        hcnt <= '0;
        bcnt <= '0;
        phase <= 1'b0;
        if (cmd_en) begin
          wr_q <= cmd_write;
          frame <= {32'hFFFF_FFFF, 2'b01, cmd_write ? 2'b01 : 2'b10, phy_addr, reg_addr, 2'b10, wr_data};
        end
      end else begin
        hcnt <= half_end ? '0 : hcnt + HW'(1);
        if (half_end) phase <= ~phase;
        if (bit_end) bcnt <= bcnt + 6'd1;
        if (bit_end && !wr_q && bcnt >= 6'd48) shreg <= {shreg[14:0], sync[1]};
        if (last && !wr_q) rd_data <= {shreg[14:0], sync[1]};
      end
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = cmd_en ? PREAMBLE : IDLE;
      PREAMBLE:   state_nxt = (bit_end && bcnt == 6'd31) ? HEADER : PREAMBLE;
      HEADER:     state_nxt = (bit_end && bcnt == 6'd45) ? TURNAROUND : HEADER;
      TURNAROUND: state_nxt = (bit_end && bcnt == 6'd47) ? DATA : TURNAROUND;
      DATA:       state_nxt = last ? IDLE : DATA;
      default:    state_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = done_q;
    mdc = busy && phase;
    mdio_oe = busy && (wr_q || bcnt < 6'd46);
    mdio_out = busy ? frame[6'd63 - bcnt] : 1'b1;
  end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: scoreboard bench for mdio_master at MDC_HALF_PERIOD 20 and 2
module tb_mdio_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rst, cmd_en, busy, done, mdc, mdio_out, mdio_oe, mdio_in;
  logic cmd_write;
  logic [4:0] phy_addr, reg_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data [2];
  logic [15:0] pdata [2];
  logic [15:0] last_rd [2];
  int hp [2] = '{20, 2};
  int checks = 0, failures = 0;
  typedef struct {
    int inst;
    logic [63:0] frame;
    logic [63:0] mask;
    logic [15:0] rd;
    int lat;
  } exp_t;
  exp_t q[$];
  exp_t e;
  mdio_master #(.MDC_HALF_PERIOD(20)) u0 (
    .clk(clk), .rst(rst[0]), .cmd_en(cmd_en[0]), .cmd_write(cmd_write),
    .phy_addr(phy_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .busy(busy[0]), .done(done[0]), .rd_data(rd_data[0]), .mdc(mdc[0]),
    .mdio_out(mdio_out[0]), .mdio_oe(mdio_oe[0]), .mdio_in(mdio_in[0])
  );
  mdio_master #(.MDC_HALF_PERIOD(2)) u1 (
    .clk(clk), .rst(rst[1]), .cmd_en(cmd_en[1]), .cmd_write(cmd_write),
    .phy_addr(phy_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .busy(busy[1]), .done(done[1]), .rd_data(rd_data[1]), .mdc(mdc[1]),
    .mdio_out(mdio_out[1]), .mdio_oe(mdio_oe[1]), .mdio_in(mdio_in[1])
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic expect_frame(input int i, input logic wr, input logic [15:0] pd, input logic [63:0] fr);
    exp_t x;
    x.inst = i;
    x.frame = fr;
    x.mask = wr ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFC_0000;
    if (!wr) last_rd[i] = pd;
    x.rd = last_rd[i];
    x.lat = 1 + 128 * hp[i];
    q.push_back(x);
  endtask
  task automatic drive(input int i, input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input logic [15:0] pd);
    @(negedge clk);
    cmd_write = wr;
    phy_addr = pa;
    reg_addr = ra;
    wr_data = wd;
    pdata[i] = pd;
    cmd_en[i] = 1'b1;
    @(negedge clk);
    cmd_en[i] = 1'b0;
  endtask
  task automatic issue(input int i, input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input logic [15:0] pd, input logic [63:0] fr);
    expect_frame(i, wr, pd, fr);
    drive(i, wr, pa, ra, wd, pd);
  endtask
  task automatic wait_done(input int i, input int budget);
    int k = 0;
    while (!done[i] && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done[i]) begin
      checks++;
      failures++;
      $display("FAIL done_timeout inst=%0d got no done expected done within %0d cycles", i, budget);
    end
  endtask
  longint cyc = 0;
  longint start [2], lastr [2];
  int edges [2], perr [2];
  logic [63:0] cap [2], ocap [2];
  logic pb [2] = '{1'b0, 1'b0};
  logic pm [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (busy[i] && !pb[i]) begin
        start[i] = cyc - 1;
        edges[i] = 0;
        perr[i] = 0;
        cap[i] = '0;
        ocap[i] = '0;
      end
      if (mdc[i] && !pm[i]) begin
        if (edges[i] > 0 && cyc - lastr[i] != longint'(2 * hp[i])) perr[i]++;
        lastr[i] = cyc;
        edges[i]++;
        cap[i] = {cap[i][62:0], mdio_out[i]};
        ocap[i] = {ocap[i][62:0], mdio_oe[i]};
      end
      if (done[i]) begin
        if (q.size() == 0 || q[0].inst != i) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done inst=%0d got done expected none", i);
        end else begin
          e = q.pop_front();
          chk("frame_bits", cap[i] & e.mask, e.frame & e.mask);
          chk("oe_per_bit", ocap[i], e.mask);
          chk("mdc_rising_edges", 64'(edges[i]), 64'd64);
          chk("latency", 64'(cyc - start[i]), 64'(e.lat));
          chk("mdc_period_errs", 64'(perr[i]), 64'd0);
          chk("rd_data_at_done", 64'(rd_data[i]), 64'(e.rd));
          chk("done_cycle_busy_mdc_oe", {61'd0, busy[i], mdc[i], mdio_oe[i]}, 64'd0);
        end
      end
      pb[i] = busy[i];
      pm[i] = mdc[i];
    end
  end
  int n [2] = '{0, 0};
  logic ppm [2] = '{1'b0, 1'b0};
  logic [3:0] bi;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!busy[i]) n[i] = 0;
      else if (mdc[i] && !ppm[i]) n[i]++;
      else if (!mdc[i] && ppm[i]) begin
        bi = 4'(63 - n[i]);
        mdio_in[i] = (n[i] >= 48 && n[i] <= 63) ? pdata[i][bi] : 1'b1;
      end
      ppm[i] = mdc[i];
    end
  end
  initial begin
    rst = 2'b11;
    cmd_en = 2'b11;
    cmd_write = 1'b1;
    phy_addr = '0;
    reg_addr = '0;
    wr_data = '0;
    mdio_in = 2'b11;
    pdata = '{16'h0, 16'h0};
    last_rd = '{16'h0, 16'h0};
    repeat (3) @(negedge clk);
    rst = 2'b00;
    cmd_en = 2'b00;
    for (int i = 0; i < 2; i++) begin
      chk("reset_busy_done_mdc_oe_out", {59'd0, busy[i], done[i], mdc[i], mdio_oe[i], mdio_out[i]}, 64'd1);
      chk("reset_rd_data", 64'(rd_data[i]), 64'd0);
    end
    @(negedge clk);
    chk("cmd_en_during_reset_ignored", 64'(busy), 64'd0);
    issue(0, 1'b1, 5'h01, 5'h00, 16'h1140, 16'h0, 64'hFFFF_FFFF_5082_1140);
    wait_done(0, 3000);
    issue(0, 1'b0, 5'h03, 5'h02, 16'h0, 16'h0141, 64'hFFFF_FFFF_6188_0000);
    wait_done(0, 3000);
    issue(0, 1'b1, 5'h1F, 5'h1F, 16'hA5A5, 16'h0, 64'hFFFF_FFFF_5FFE_A5A5);
    repeat (98) @(negedge clk);
    cmd_write = 1'b0;
    phy_addr = 5'h00;
    reg_addr = 5'h00;
    wr_data = 16'h0000;
    cmd_en[0] = 1'b1;
    @(negedge clk);
    cmd_en[0] = 1'b0;
    wait_done(0, 3000);
    repeat (50) @(negedge clk);
    chk("busy_ignore_no_second_frame", 64'(busy[0]), 64'd0);
    @(negedge clk);
    cmd_write = 1'b1;
    phy_addr = 5'h01;
    reg_addr = 5'h00;
    wr_data = 16'h1140;
    cmd_en[0] = 1'b1;
    expect_frame(0, 1'b1, 16'h0, 64'hFFFF_FFFF_5082_1140);
    expect_frame(0, 1'b1, 16'h0, 64'hFFFF_FFFF_5112_BEEF);
    @(negedge clk);
    phy_addr = 5'h02;
    reg_addr = 5'h04;
    wr_data = 16'hBEEF;
    wait_done(0, 3000);
    @(negedge clk);
    cmd_en[0] = 1'b0;
    chk("b2b_bit0_busy_mdc_oe_out", {60'd0, busy[0], mdc[0], mdio_oe[0], mdio_out[0]}, 64'hB);
    wait_done(0, 3000);
    @(negedge clk);
    chk("rd_data_kept_after_writes", 64'(rd_data[0]), 64'h0141);
    drive(0, 1'b0, 5'h03, 5'h02, 16'h0, 16'hFFFF);
    repeat (2100) @(negedge clk);
    chk("in_data_state_busy", 64'(busy[0]), 64'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("abort_busy_done_mdc_oe", {60'd0, busy[0], done[0], mdc[0], mdio_oe[0]}, 64'd0);
    chk("abort_rd_data", 64'(rd_data[0]), 64'd0);
    last_rd[0] = 16'h0;
    repeat (3000) @(negedge clk);
    issue(1, 1'b1, 5'h01, 5'h00, 16'h1140, 16'h0, 64'hFFFF_FFFF_5082_1140);
    wait_done(1, 400);
    issue(1, 1'b0, 5'h03, 5'h02, 16'h0, 16'h0141, 64'hFFFF_FFFF_6188_0000);
    wait_done(1, 400);
    issue(1, 1'b0, 5'h1F, 5'h00, 16'h0, 16'h8001, 64'hFFFF_FFFF_6F80_0000);
    wait_done(1, 400);
    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
